// File: rtl/fp_wb_queue.sv
// fp_wb_queue: in-order FPU result writeback FIFO with sticky fflags and pending-rd hazard query.
// Optional same-cycle bypass of an empty queue when FP_WB_BYPASS_EN is defined.
// Ports: clk_i/rst_i (sync active-high); fpu_* push side (valid/ready, result, status, rd);
// flush_i drops all entries; wb_* pop side to the FP register file; fflags_o/fflags_clr_i
// sticky flags; chk_rd_i/chk_hit_o hazard query; count_o/busy_o occupancy.
module fp_wb_queue #(
  parameter int DATAWIDTH = 32,
  parameter int DEPTH = 4,
  parameter int STATUS_W = 5
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     fpu_valid_i,
  output logic                     fpu_ready_o,
  input  logic [DATAWIDTH-1:0]     fpu_result_i,
  input  logic [STATUS_W-1:0]      fpu_status_i,
  input  logic [4:0]               fpu_rd_i,
  input  logic                     flush_i,
  output logic                     wb_valid_o,
  input  logic                     wb_ready_i,
  output logic [4:0]               wb_rd_o,
  output logic [DATAWIDTH-1:0]     wb_data_o,
  output logic [STATUS_W-1:0]      fflags_o,
  input  logic                     fflags_clr_i,
  input  logic [4:0]               chk_rd_i,
  output logic                     chk_hit_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     busy_o
);
  localparam int AW = $clog2(DEPTH);
  logic [DATAWIDTH-1:0] data_q [DEPTH];
  logic [STATUS_W-1:0] status_q [DEPTH];
  logic [4:0] rd_q [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, off;
  logic [AW:0] count;
  logic [STATUS_W-1:0] fflags;
  logic byp, take, push, pop, hit;
`ifdef FP_WB_BYPASS_EN
  assign byp = (count == '0) && fpu_valid_i && !flush_i;
`else
  assign byp = 1'b0;
`endif
  // a bypassed result accepted by the register file never enters the FIFO
  assign take = byp && wb_ready_i;
  assign fpu_ready_o = count != (AW+1)'(DEPTH);
  assign push = fpu_valid_i && fpu_ready_o && !take;
  assign pop = (count != '0) && wb_ready_i;
  assign wb_valid_o = (count != '0) || byp;
  assign wb_rd_o = byp ? fpu_rd_i : rd_q[rd_ptr];
  assign wb_data_o = byp ? fpu_result_i : data_q[rd_ptr];
  assign fflags_o = fflags;
  assign count_o = count;
  assign busy_o = count != '0;
  assign chk_hit_o = hit;
  // a slot is live when its distance from rd_ptr (mod DEPTH) is below count
  always_comb begin
    hit = byp && (fpu_rd_i == chk_rd_i);
    off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = AW'(i) - rd_ptr;
      hit = hit | (({1'b0, off} < count) && (rd_q[i] == chk_rd_i));
    end
  end
  always_ff @(posedge clk_i) begin
    if (push && !flush_i) begin
      data_q[wr_ptr] <= fpu_result_i;
      status_q[wr_ptr] <= fpu_status_i;
      rd_q[wr_ptr] <= fpu_rd_i;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      fflags <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= (push && !pop) ? count + 1'b1 : (pop && !push) ? count - 1'b1 : count;
      fflags <= pop ? (fflags_clr_i ? '0 : fflags) | status_q[rd_ptr] :
                take ? (fflags_clr_i ? '0 : fflags) | fpu_status_i :
                fflags_clr_i ? '0 : fflags;
    end
  end
endmodule

// File: tb/tb_fp_wb_queue.sv
// tb_fp_wb_queue: directed plus random scoreboard bench for fp_wb_queue.
module tb_fp_wb_queue;
  logic clk = 1'b0;
  logic rst, fpu_valid, fpu_ready, flush, wb_valid, wb_ready, fflags_clr, chk_hit, busy;
  logic [31:0] fpu_result, wb_data;
  logic [4:0] fpu_status, fpu_rd, wb_rd, fflags, chk_rd;
  logic [2:0] count;
  typedef struct {
    logic [4:0] rd;
    logic [31:0] data;
    logic [4:0] st;
  } ent_t;
  ent_t sb[$];
  logic [4:0] mflags;
  int ncmp = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  fp_wb_queue dut (
    .clk_i(clk), .rst_i(rst), .fpu_valid_i(fpu_valid), .fpu_ready_o(fpu_ready),
    .fpu_result_i(fpu_result), .fpu_status_i(fpu_status), .fpu_rd_i(fpu_rd),
    .flush_i(flush), .wb_valid_o(wb_valid), .wb_ready_i(wb_ready), .wb_rd_o(wb_rd),
    .wb_data_o(wb_data), .fflags_o(fflags), .fflags_clr_i(fflags_clr), .chk_rd_i(chk_rd),
    .chk_hit_o(chk_hit), .count_o(count), .busy_o(busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic [4:0] rd, input logic [31:0] d, input logic [4:0] st,
                     input logic rr, input logic fl, input logic clr, input logic [4:0] crd);
    logic er, ev, eh, byp, push, pop;
    fpu_valid = v; fpu_rd = rd; fpu_result = d; fpu_status = st;
    wb_ready = rr; flush = fl; fflags_clr = clr; chk_rd = crd;
    @(negedge clk);
    er = sb.size() != 4;
    byp = 1'b0;
`ifdef FP_WB_BYPASS_EN
    byp = sb.size() == 0 && v && !fl;
`endif
    ev = sb.size() != 0 || byp;
    eh = byp && rd == crd;
    foreach (sb[i]) if (sb[i].rd == crd) eh = 1'b1;
    chk("fpu_ready", 64'(fpu_ready), 64'(er));
    chk("wb_valid", 64'(wb_valid), 64'(ev));
    chk("chk_hit", 64'(chk_hit), 64'(eh));
    if (ev) begin
      chk("wb_rd", 64'(wb_rd), 64'(byp ? rd : sb[0].rd));
      chk("wb_data", 64'(wb_data), 64'(byp ? d : sb[0].data));
    end
    push = v && er;
    pop = ev && rr;
    if (fl) sb.delete();
    else if (byp && rr) mflags = (clr ? 5'd0 : mflags) | st;
    else begin
      if (pop) begin
        mflags = (clr ? 5'd0 : mflags) | sb[0].st;
        void'(sb.pop_front());
      end else if (clr) mflags = 5'd0;
      if (push) sb.push_back('{rd, d, st});
    end
    @(posedge clk);
    #1;
    chk("count", 64'(count), 64'(sb.size()));
    chk("busy", 64'(busy), 64'(sb.size() != 0));
    chk("fflags", 64'(fflags), 64'(mflags));
  endtask

  task automatic reset_check;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    sb.delete();
    mflags = 5'd0;
    chk("rst_ready", 64'(fpu_ready), 64'd1);
    chk("rst_valid", 64'(wb_valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_fflags", 64'(fflags), 64'd0);
    chk("rst_hit", 64'(chk_hit), 64'd0);
    rst = 1'b0;
  endtask

  initial begin
    fpu_valid = 0; fpu_result = 0; fpu_status = 0; fpu_rd = 0; flush = 0;
    wb_ready = 0; fflags_clr = 0; chk_rd = 0; mflags = 0;
    reset_check();
    // single push then pop with 1-cycle latency
    cyc(1, 5'd3, 32'h3F800000, 5'd0, 1, 0, 0, 5'd3);
    cyc(0, 5'd0, 32'h0, 5'd0, 1, 0, 0, 5'd3);
    // fill to full, refuse 5th push, drain across wrap
    for (int i = 1; i <= 4; i++) cyc(1, 5'(i), 32'h1000 + 32'(i), 5'd0, 0, 0, 0, 5'd2);
    cyc(1, 5'd5, 32'h1005, 5'd0, 0, 0, 0, 5'd5);
    cyc(1, 5'd6, 32'h1006, 5'd0, 1, 0, 0, 5'd4);
    for (int i = 0; i < 4; i++) cyc(0, 5'd0, 32'h0, 5'd0, 1, 0, 0, 5'd2);
    // sticky flags and clear-with-pop
    cyc(1, 5'd10, 32'hA, 5'b00001, 0, 0, 0, 5'd0);
    cyc(1, 5'd11, 32'hB, 5'b10000, 0, 0, 0, 5'd0);
    cyc(0, 5'd0, 32'h0, 5'd0, 1, 0, 0, 5'd0);
    cyc(0, 5'd0, 32'h0, 5'd0, 1, 0, 0, 5'd0);
    chk("fflags_10001", 64'(fflags), 64'h11);
    cyc(1, 5'd12, 32'hC, 5'b00100, 0, 0, 0, 5'd0);
    cyc(0, 5'd0, 32'h0, 5'd0, 1, 0, 1, 5'd0);
    chk("fflags_clrpop", 64'(fflags), 64'h04);
    // hazard query
    cyc(1, 5'd7, 32'h7, 5'd0, 0, 0, 0, 5'd2);
    cyc(1, 5'd9, 32'h9, 5'd0, 0, 0, 0, 5'd9);
    cyc(0, 5'd0, 32'h0, 5'd0, 0, 0, 0, 5'd9);
    cyc(0, 5'd0, 32'h0, 5'd0, 0, 0, 0, 5'd2);
    cyc(0, 5'd0, 32'h0, 5'd0, 1, 0, 0, 5'd9);
    cyc(0, 5'd0, 32'h0, 5'd0, 1, 0, 0, 5'd9);
    cyc(0, 5'd0, 32'h0, 5'd0, 0, 0, 0, 5'd9);
    // flush with concurrent push
    for (int i = 0; i < 3; i++) cyc(1, 5'(20 + i), 32'h2000 + 32'(i), 5'b01000, 0, 0, 0, 5'd21);
    cyc(1, 5'd30, 32'h3000, 5'b00010, 1, 1, 0, 5'd21);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'(wb_valid), 64'd0);
    chk("flush_fflags", 64'(fflags), 64'h04);
    // sustained push+pop
    cyc(1, 5'd1, 32'h5001, 5'd0, 1, 0, 0, 5'd1);
    for (int i = 2; i < 8; i++) cyc(1, 5'(i), 32'h5000 + 32'(i), 5'(i), 1, 0, 0, 5'(i));
    cyc(0, 5'd0, 32'h0, 5'd0, 1, 0, 0, 5'd0);
    // random traffic
    for (int i = 0; i < 80; i++)
      cyc(($urandom % 4) != 0, 5'($urandom_range(0, 31)), $urandom, 5'($urandom_range(0, 31)),
          ($urandom % 2) == 0, ($urandom % 20) == 0, ($urandom % 10) == 0, 5'($urandom_range(0, 31)));
    // reset mid-operation
    cyc(1, 5'd13, 32'hD, 5'b11111, 0, 0, 0, 5'd0);
    cyc(1, 5'd14, 32'hE, 5'd0, 0, 0, 0, 5'd0);
    cyc(0, 5'd0, 32'h0, 5'd0, 1, 0, 0, 5'd0);
    fpu_valid = 0; wb_ready = 0; flush = 0; fflags_clr = 0;
    reset_check();
    cyc(1, 5'd15, 32'hF, 5'd1, 1, 0, 0, 5'd15);
    cyc(0, 5'd0, 32'h0, 5'd0, 1, 0, 0, 5'd15);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
